// File: rtl/lsq_ordered_if.sv
// Dispatch, CDB, ROB, data-memory and result signals of the in-order load/store queue.
// slave = the queue, master = its environment (dispatch/CDB/ROB/memory/arbiter).
interface lsq_ordered_if #(parameter int ROB_W = 4);
    logic             disp_valid;
    logic [31:0]      disp_inst;
    logic [ROB_W-1:0] disp_rob;
    logic             disp_s1_rdy;
    logic [ROB_W-1:0] disp_s1_tag;
    logic [31:0]      disp_s1_val;
    logic             disp_s2_rdy;
    logic [ROB_W-1:0] disp_s2_tag;
    logic [31:0]      disp_s2_val;
    logic             lsq_avai;
    logic             cdb_en;
    logic [ROB_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             store_on;
    logic             ls_commit;
    logic [31:0]      dmem_addr;
    logic [3:0]       dmem_rmask;
    logic [3:0]       dmem_wmask;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata;
    logic             dmem_resp;
    logic             res_valid;
    logic             res_ack;
    logic [ROB_W-1:0] res_rob;
    logic [31:0]      res_data;
    logic [31:0]      res_addr;

    modport slave (
        input  disp_valid, disp_inst, disp_rob,
        input  disp_s1_rdy, disp_s1_tag, disp_s1_val,
        input  disp_s2_rdy, disp_s2_tag, disp_s2_val,
        output lsq_avai,
        input  cdb_en, cdb_tag, cdb_data, store_on, ls_commit,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        output res_valid, res_rob, res_data, res_addr,
        input  res_ack
    );

    modport master (
        output disp_valid, disp_inst, disp_rob,
        output disp_s1_rdy, disp_s1_tag, disp_s1_val,
        output disp_s2_rdy, disp_s2_tag, disp_s2_val,
        input  lsq_avai,
        output cdb_en, cdb_tag, cdb_data, store_on, ls_commit,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        input  res_valid, res_rob, res_data, res_addr,
        output res_ack
    );
endinterface

// File: rtl/lsq_ordered.sv
// In-order load/store queue: entries allocated at dispatch, one memory access outstanding, freed on ROB commit.
// Optional LSQ_FLUSH_EN adds a flush input that empties the queue and swallows an in-flight response.
module lsq_ordered #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef LSQ_FLUSH_EN
    input  logic flush,
`endif
    lsq_ordered_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] PTR_ONE = {{IW{1'b0}}, 1'b1};

    typedef struct packed {
        logic             valid;
        logic             is_store;
        logic             done;
        logic [2:0]       f3;
        logic [31:0]      imm;
        logic [ROB_W-1:0] rob;
        logic             s1_rdy;
        logic [ROB_W-1:0] s1_tag;
        logic [31:0]      s1_val;
        logic             s2_rdy;
        logic [ROB_W-1:0] s2_tag;
        logic [31:0]      s2_val;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    entry_t      q [DEPTH];
    logic [IW:0] head, iss, tail;
    state_t      state, state_n;
    logic [31:0] acc_addr;
    logic        flush_w, drop;

`ifdef LSQ_FLUSH_EN
    assign flush_w = flush;
    // A flushed access still owes us a response; hold off new accesses until it shows up.
    always_ff @(posedge clk) begin
        if (rst)
            drop <= 1'b0;
        else if (flush && state == ACCESS && !bus.dmem_resp)
            drop <= 1'b1;
        else if (drop && bus.dmem_resp)
            drop <= 1'b0;
    end
`else
    assign flush_w = 1'b0;
    assign drop    = 1'b0;
`endif

    logic full;
    assign full = (head[IW] != tail[IW]) && (head[IW-1:0] == tail[IW-1:0]);
    assign bus.lsq_avai  = !full;
    assign bus.res_valid = (state == DONE);

    entry_t ie;
    logic   can_issue, complete;
    assign ie = q[iss[IW-1:0]];
    assign can_issue = ie.valid && !ie.done && ie.s1_rdy && !drop &&
                       (!ie.is_store || (ie.s2_rdy && iss == head && bus.store_on));
    assign complete = (state == ACCESS) && bus.dmem_resp && !flush_w;

    logic [31:0] ea, lane_data, ld_val;
    logic [3:0]  mask;
    assign ea = ie.s1_val + ie.imm;
    always_comb begin
        mask = 4'b1111;
        case (ie.f3[1:0])
            2'b00:   mask = 4'b0001 << ea[1:0];
            2'b01:   mask = 4'b0011 << ea[1:0];
            default: mask = 4'b1111;
        endcase
    end

    assign lane_data = bus.dmem_rdata >> {acc_addr[1:0], 3'b000};
    always_comb begin
        ld_val = lane_data;
        case (ie.f3)
            3'b000:  ld_val = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  ld_val = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  ld_val = {24'b0, lane_data[7:0]};
            3'b101:  ld_val = {16'b0, lane_data[15:0]};
            default: ld_val = lane_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (can_issue)     state_n = ACCESS;
            ACCESS:  if (bus.dmem_resp) state_n = DONE;
            DONE:    if (bus.res_ack)   state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush_w) state_n = IDLE;
    end

    // Memory port and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dmem_addr  <= '0;
            bus.dmem_rmask <= '0;
            bus.dmem_wmask <= '0;
            bus.dmem_wdata <= '0;
            acc_addr       <= '0;
            bus.res_rob    <= '0;
            bus.res_data   <= '0;
            bus.res_addr   <= '0;
        end else begin
            if (state == IDLE && state_n == ACCESS) begin
                bus.dmem_addr  <= {ea[31:2], 2'b00};
                acc_addr       <= ea;
                bus.dmem_rmask <= ie.is_store ? 4'b0000 : mask;
                bus.dmem_wmask <= ie.is_store ? mask : 4'b0000;
                bus.dmem_wdata <= ie.is_store ? (ie.s2_val << {ea[1:0], 3'b000}) : 32'b0;
            end else if (state == ACCESS && (bus.dmem_resp || flush_w)) begin
                bus.dmem_rmask <= '0;
                bus.dmem_wmask <= '0;
            end
            if (complete) begin
                bus.res_rob  <= ie.rob;
                bus.res_data <= ie.is_store ? 32'b0 : ld_val;
                bus.res_addr <= acc_addr;
            end
        end
    end

    logic d_store, s1_hit, s2_hit;
    logic [31:0] d_imm;
    assign d_store = (bus.disp_inst[6:0] == 7'b0100011);
    assign d_imm   = d_store ? {{20{bus.disp_inst[31]}}, bus.disp_inst[31:25], bus.disp_inst[11:7]}
                             : {{20{bus.disp_inst[31]}}, bus.disp_inst[31:20]};
    assign s1_hit  = bus.cdb_en && (bus.cdb_tag == bus.disp_s1_tag);
    assign s2_hit  = bus.cdb_en && (bus.cdb_tag == bus.disp_s2_tag);

    logic unused_ok;
    assign unused_ok = ^bus.disp_inst[19:15];

    // Queue storage and pointers; dispatch, snoop, completion and commit touch distinct entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            iss  <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (flush_w) begin
            iss  <= head;
            tail <= head;
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.cdb_en && q[i].valid) begin
                    if (!q[i].s1_rdy && q[i].s1_tag == bus.cdb_tag) begin
                        q[i].s1_rdy <= 1'b1;
                        q[i].s1_val <= bus.cdb_data;
                    end
                    if (!q[i].s2_rdy && q[i].s2_tag == bus.cdb_tag) begin
                        q[i].s2_rdy <= 1'b1;
                        q[i].s2_val <= bus.cdb_data;
                    end
                end
            end
            if (bus.disp_valid && !full) begin
                q[tail[IW-1:0]] <= '{
                    valid:    1'b1,
                    is_store: d_store,
                    done:     1'b0,
                    f3:       bus.disp_inst[14:12],
                    imm:      d_imm,
                    rob:      bus.disp_rob,
                    s1_rdy:   bus.disp_s1_rdy || s1_hit,
                    s1_tag:   bus.disp_s1_tag,
                    s1_val:   bus.disp_s1_rdy ? bus.disp_s1_val : bus.cdb_data,
                    s2_rdy:   !d_store || bus.disp_s2_rdy || s2_hit,
                    s2_tag:   bus.disp_s2_tag,
                    s2_val:   (!d_store || bus.disp_s2_rdy) ? bus.disp_s2_val : bus.cdb_data
                };
                tail <= tail + PTR_ONE;
            end
            if (complete) begin
                q[iss[IW-1:0]].done <= 1'b1;
                iss <= iss + PTR_ONE;
            end
            if (bus.ls_commit && q[head[IW-1:0]].valid) begin
                q[head[IW-1:0]].valid <= 1'b0;
                head <= head + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_lsq_ordered.sv
// Directed, table-driven bench for lsq_ordered (DEPTH=4); inputs change and outputs are sampled at negedge.
module tb_lsq_ordered;
    logic clk = 1'b0;
    logic rst;
`ifdef LSQ_FLUSH_EN
    logic flush;
`endif

    lsq_ordered_if #(.ROB_W(4)) bus ();

    lsq_ordered #(.DEPTH(4), .ROB_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef LSQ_FLUSH_EN
        .flush(flush),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] ld(input logic [2:0] f3, input logic [11:0] imm);
        return {imm, 5'd1, f3, 5'd2, 7'b0000011};
    endfunction

    function automatic logic [31:0] st(input logic [2:0] f3, input logic [11:0] imm);
        return {imm[11:5], 5'd3, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic dispatch(input logic [31:0] inst, input logic [3:0] rob, input logic s1_rdy,
                            input logic [3:0] s1_tag, input logic [31:0] s1_val, input logic [31:0] s2_val);
        bus.disp_valid  = 1'b1;
        bus.disp_inst   = inst;
        bus.disp_rob    = rob;
        bus.disp_s1_rdy = s1_rdy;
        bus.disp_s1_tag = s1_tag;
        bus.disp_s1_val = s1_val;
        bus.disp_s2_rdy = 1'b1;
        bus.disp_s2_tag = 4'd0;
        bus.disp_s2_val = s2_val;
        step();
        bus.disp_valid  = 1'b0;
    endtask

    task automatic wait_access(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if ((bus.dmem_rmask | bus.dmem_wmask) != 4'b0) seen = 1'b1;
            else step();
        end
        if (!seen) check({name, "_access_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic serve(input string name, input logic [31:0] rdata, input logic [3:0] rob,
                         input logic [31:0] res, input logic [31:0] baddr);
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = rdata;
        step();
        bus.dmem_resp  = 1'b0;
        check({name, "_res_valid"}, {31'b0, bus.res_valid}, 32'd1);
        check({name, "_res_rob"},   {28'b0, bus.res_rob}, {28'b0, rob});
        check({name, "_res_data"},  bus.res_data, res);
        check({name, "_res_addr"},  bus.res_addr, baddr);
        check({name, "_mask_clr"},  {24'b0, bus.dmem_rmask, bus.dmem_wmask}, 32'd0);
        bus.res_ack   = 1'b1;
        bus.ls_commit = 1'b1;
        step();
        bus.res_ack   = 1'b0;
        bus.ls_commit = 1'b0;
        check({name, "_res_drop"},  {31'b0, bus.res_valid}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] base;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] waddr;
        logic [31:0] baddr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] res;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{ld(3'b010, 12'd4),     32'h100, 32'h0,        32'hDEADBEEF, 32'h104, 32'h104, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{ld(3'b000, 12'd0),     32'h203, 32'h0,        32'h80FFFFFF, 32'h200, 32'h203, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[2] = '{ld(3'b100, 12'd0),     32'h203, 32'h0,        32'h80FFFFFF, 32'h200, 32'h203, 4'b1000, 32'h0,        32'h00000080};
        vecs[3] = '{ld(3'b001, 12'd2),     32'h100, 32'h0,        32'h80011234, 32'h100, 32'h102, 4'b1100, 32'h0,        32'hFFFF8001};
        vecs[4] = '{ld(3'b101, 12'hFFE),   32'h104, 32'h0,        32'h80011234, 32'h100, 32'h102, 4'b1100, 32'h0,        32'h00008001};
        vecs[5] = '{ld(3'b000, 12'd1),     32'h400, 32'h0,        32'h11227F44, 32'h400, 32'h401, 4'b0010, 32'h0,        32'h0000007F};
        vecs[6] = '{st(3'b010, 12'd8),     32'h500, 32'hCAFEF00D, 32'h0,        32'h508, 32'h508, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[7] = '{st(3'b000, 12'd1),     32'h300, 32'h000000AB, 32'h0,        32'h300, 32'h301, 4'b0010, 32'h0000AB00, 32'h0};
        vecs[8] = '{st(3'b001, 12'hFFC),   32'h306, 32'h00001234, 32'h0,        32'h300, 32'h302, 4'b1100, 32'h12340000, 32'h0};

        rst = 1'b1;
`ifdef LSQ_FLUSH_EN
        flush = 1'b0;
`endif
        bus.disp_valid = 1'b0; bus.disp_inst = '0; bus.disp_rob = '0;
        bus.disp_s1_rdy = 1'b0; bus.disp_s1_tag = '0; bus.disp_s1_val = '0;
        bus.disp_s2_rdy = 1'b0; bus.disp_s2_tag = '0; bus.disp_s2_val = '0;
        bus.cdb_en = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.store_on = 1'b0; bus.ls_commit = 1'b0;
        bus.dmem_rdata = '0; bus.dmem_resp = 1'b0; bus.res_ack = 1'b0;
        step();
        step();
        check("rst_avai",  {31'b0, bus.lsq_avai}, 32'd1);
        check("rst_valid", {31'b0, bus.res_valid}, 32'd0);
        check("rst_masks", {24'b0, bus.dmem_rmask, bus.dmem_wmask}, 32'd0);
        check("rst_addr",  bus.dmem_addr, 32'd0);
        check("rst_wdata", bus.dmem_wdata, 32'd0);
        check("rst_res",   bus.res_data | bus.res_addr | {28'b0, bus.res_rob}, 32'd0);
        rst = 1'b0;

        // Table: one instruction at a time through dispatch, access, result and commit.
        for (int i = 0; i < 9; i++) begin
            logic st_op;
            st_op = (vecs[i].inst[6:0] == 7'b0100011);
            dispatch(vecs[i].inst, 4'(i + 1), 1'b1, 4'd0, vecs[i].base, vecs[i].sdata);
            bus.store_on = st_op;
            wait_access($sformatf("v%0d", i));
            check($sformatf("v%0d_addr", i),  bus.dmem_addr, vecs[i].waddr);
            check($sformatf("v%0d_rmask", i), {28'b0, bus.dmem_rmask}, st_op ? 32'd0 : {28'b0, vecs[i].mask});
            check($sformatf("v%0d_wmask", i), {28'b0, bus.dmem_wmask}, st_op ? {28'b0, vecs[i].mask} : 32'd0);
            if (st_op) check($sformatf("v%0d_wdata", i), bus.dmem_wdata, vecs[i].wdata);
            serve($sformatf("v%0d", i), vecs[i].rdata, 4'(i + 1), vecs[i].res, vecs[i].baddr);
            bus.store_on = 1'b0;
        end

        // Store held back until the ROB head is a store.
        dispatch(st(3'b001, 12'd2), 4'd7, 1'b1, 4'd0, 32'h300, 32'h1234);
        step(); step(); step();
        check("gate_wmask_hold", {28'b0, bus.dmem_wmask}, 32'd0);
        bus.store_on = 1'b1;
        step();
        check("gate_wmask", {28'b0, bus.dmem_wmask}, 32'h0000000C);
        check("gate_wdata", bus.dmem_wdata, 32'h12340000);
        check("gate_addr",  bus.dmem_addr, 32'h300);
        serve("gate", 32'h0, 4'd7, 32'h0, 32'h302);
        bus.store_on = 1'b0;

        // Base operand arrives over the CDB.
        dispatch(ld(3'b010, 12'd0), 4'd6, 1'b0, 4'd5, 32'h0, 32'h0);
        step();
        check("cdb_wait", {28'b0, bus.dmem_rmask}, 32'd0);
        bus.cdb_en = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_data = 32'h400;
        step();
        bus.cdb_en = 1'b0;
        check("cdb_capture_edge", {28'b0, bus.dmem_rmask}, 32'd0);
        step();
        check("cdb_rmask", {28'b0, bus.dmem_rmask}, 32'h0000000F);
        check("cdb_addr",  bus.dmem_addr, 32'h400);
        serve("cdb", 32'h55AA55AA, 4'd6, 32'h55AA55AA, 32'h400);

        // Fill, rejected fifth dispatch, commit one, wrap tail.
        for (int k = 0; k < 4; k++)
            dispatch(ld(3'b010, 12'd0), 4'(k + 1), 1'b1, 4'd0, 32'h1000 + 32'(k * 16), 32'h0);
        check("full_avai", {31'b0, bus.lsq_avai}, 32'd0);
        dispatch(ld(3'b010, 12'd0), 4'd9, 1'b1, 4'd0, 32'h2000, 32'h0);
        check("full_ignore_avai", {31'b0, bus.lsq_avai}, 32'd0);
        wait_access("full0");
        serve("full0", 32'h11, 4'd1, 32'h11, 32'h1000);
        check("full_free_avai", {31'b0, bus.lsq_avai}, 32'd1);
        dispatch(ld(3'b010, 12'd0), 4'd5, 1'b1, 4'd0, 32'h1040, 32'h0);
        check("wrap_full_avai", {31'b0, bus.lsq_avai}, 32'd0);
        for (int k = 1; k < 5; k++) begin
            wait_access($sformatf("wrap%0d", k));
            check($sformatf("wrap%0d_addr", k), bus.dmem_addr, 32'h1000 + 32'(k * 16));
            serve($sformatf("wrap%0d", k), 32'(k * 32'h22), 4'(k + 1), 32'(k * 32'h22), 32'h1000 + 32'(k * 16));
        end
        check("wrap_empty_avai", {31'b0, bus.lsq_avai}, 32'd1);

        // Reset in the middle of an access; the stale response must be ignored.
        dispatch(ld(3'b010, 12'd0), 4'd2, 1'b1, 4'd0, 32'h800, 32'h0);
        wait_access("rstmid");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_rmask", {28'b0, bus.dmem_rmask}, 32'd0);
        check("rstmid_avai",  {31'b0, bus.lsq_avai}, 32'd1);
        bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h0BADF00D;
        step();
        bus.dmem_resp = 1'b0;
        check("rstmid_no_res", {31'b0, bus.res_valid}, 32'd0);
        step();
        check("rstmid_idle", {31'b0, bus.res_valid}, 32'd0);

`ifdef LSQ_FLUSH_EN
        dispatch(ld(3'b010, 12'd0), 4'd3, 1'b1, 4'd0, 32'h600, 32'h0);
        wait_access("flush");
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_avai",  {31'b0, bus.lsq_avai}, 32'd1);
        check("flush_rmask", {28'b0, bus.dmem_rmask}, 32'd0);
        dispatch(ld(3'b010, 12'd0), 4'd4, 1'b1, 4'd0, 32'h700, 32'h0);
        step();
        check("flush_blocked", {28'b0, bus.dmem_rmask}, 32'd0);
        bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h00000BAD;
        step();
        bus.dmem_resp = 1'b0;
        check("flush_swallow", {31'b0, bus.res_valid}, 32'd0);
        wait_access("flush_next");
        check("flush_next_addr", bus.dmem_addr, 32'h700);
        serve("flush_next", 32'h12345678, 4'd4, 32'h12345678, 32'h700);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lsq_ordered.md
# lsq_ordered

Parameterised, multi-entry, in-order load/store queue for the Tomasulo RV32I core, replacing the single-entry LSQ between dispatch, the CDB, the ROB and the data-memory port. Entries are allocated in program order and capture operands from dispatch or by snooping the CDB. Memory operations issue strictly in order with one access outstanding. Results are offered to the CDB arbiter, and an entry is freed only on ROB commit, so later loads can execute while older entries wait to commit.

## Interface
- DEPTH, 4: queue entries; power of two, 2 to 16.
- ROB_W, 4: ROB tag width, $clog2(ROB_DEPTH).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- disp_valid  in  1  dispatch request; accepted when lsq_avai=1.
- disp_inst  in  32  load/store instruction word.
- disp_rob  in  ROB_W  ROB tag of the instruction.
- disp_s1_rdy, disp_s1_tag, disp_s1_val  in  1/ROB_W/32  base operand: ready flag, producer tag, value.
- disp_s2_rdy, disp_s2_tag, disp_s2_val  in  1/ROB_W/32  store-data operand; ignored for loads.
- lsq_avai  out  1  at least one free entry.
- cdb_en, cdb_tag, cdb_data  in  1/ROB_W/32  CDB broadcast.
- store_on  in  1  ROB head is a store.
- ls_commit  in  1  ROB commits the LSQ head entry.
- dmem_addr  out  32  word-aligned address.
- dmem_rmask, dmem_wmask  out  4/4  byte masks.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_rdata  in  32  read data.
- dmem_resp  in  1  access complete.
- res_valid  out  1  result offered to the CDB.
- res_ack  in  1  CDB arbiter accepted the result.
- res_rob, res_data, res_addr  out  ROB_W/32/32  result tag, load value (0 for stores), byte address.

## Operation
- Three pointers, each ROB_W-independent, $clog2(DEPTH)+1 bits, where the MSB is the wrap bit: head (oldest), iss (next to access memory), tail (next free).
  - full = pointers equal except the MSB.
  - lsq_avai = !full.
- Dispatch: entry[tail] is written with the instruction, tag and operands, and tail increments.
  - The immediate is I-type for op_load and S-type for op_store.
  - If a disp operand is not ready but matches the same-cycle CDB tag, it is captured ready.
- Snoop: every valid entry with a pending operand whose tag equals cdb_tag while cdb_en=1 captures cdb_data.
- Issue FSM, with states IDLE, ACCESS and DONE.
  - IDLE→ACCESS when entry[iss] is valid and its base is ready, and either:
    - it is a load; or
    - it is a store with data ready, iss==head and store_on=1.
  - In ACCESS, byte address = base+offset.
  - Load rmask: lb/lbu = 0001<<a[1:0]; lh/lhu = 0011<<a[1:0]; lw = 1111.
  - Store wmask is built the same way, and wdata is shifted to the matching lane.
  - ACCESS→DONE on dmem_resp.
  - A load extracts and sign- or zero-extends its data per funct3.
  - The entry is marked complete, res_valid is raised, and iss increments.
  - DONE→IDLE on res_ack.
- Stores also report through res_valid, with res_data=0, so the ROB marks them ready.
- Commit: ls_commit requires entry[head] to be complete (asserted by the bench). head increments and the entry is invalidated.
- Misaligned lh/lw addresses are not checked; masks are taken as computed.
- Dispatch, CDB capture, memory response and commit can all occur in the same cycle. Each acts on its own pointer or entry.
- Full with disp_valid=1: the request is ignored.
- Pointer wrap: handled by the MSB. DEPTH consecutive dispatches with no commits drive lsq_avai to 0.

## Timing
- Reset values:
  - head = iss = tail = 0; all entries invalid; FSM in IDLE.
  - lsq_avai=1, res_valid=0, dmem masks 0, dmem_addr=0, dmem_wdata=0.
  - res_rob, res_data and res_addr all 0.
- Dispatch takes effect at the next edge. An entry dispatched at edge N can start ACCESS at edge N+1, which drives its dmem masks during cycle N+1.
- dmem masks are registered and held constant until the dmem_resp cycle inclusive. They are 0 from the following cycle.
- res_valid rises the cycle after dmem_resp and holds until the res_ack cycle inclusive. The next ACCESS may start the cycle after the ack.
- rst asserted mid-access: all state returns to reset values at that edge. A later dmem_resp is ignored while the FSM is in IDLE.

## Configuration
- LSQ_FLUSH_EN: adds input flush (1 bit).
  - On flush=1, tail and iss are set to head and every entry is invalidated, including the head. The FSM goes to IDLE.
  - If the flush lands in ACCESS, a drop flag swallows the pending dmem_resp. No new ACCESS starts until that response arrives.
  - flush overrides dispatch and commit in the same cycle.
- Without the macro: no flush port; the queue only drains through commit.

## Test plan
- Load, all operands ready: dispatch lw with base 0x100 and offset 4, mem returns 0xDEADBEEF → dmem_rmask=1111, dmem_addr=0x104, res_data=0xDEADBEEF, res_rob=disp_rob.
- lb sign-extension: base 0x203, memory word 0x80FF_FF_FF → rmask=1000, res_data=0xFFFFFF80. lbu on the same address → 0x00000080.
- Store gated by store_on: sh with data 0x1234 to address 0x302 → wmask stays 0 until store_on=1, then wmask=1100 and wdata=0x12340000.
- CDB capture: load with base pending on tag 5; cdb_en, tag 5, data 0x400 → access starts the next cycle with dmem_addr=0x400.
- Full and wrap: with DEPTH=4, dispatch 4 entries → lsq_avai=0 and a fifth dispatch is ignored. Commit one, dispatch one → tail wraps to slot 0 and in-order results continue.
- With LSQ_FLUSH_EN: flush during a load ACCESS → the late dmem_resp produces no res_valid, lsq_avai=1, and a new load then completes normally.
